// File: rtl/ili934x_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the ILI934x write-item arbiter.
// Items are opaque ITEM_W-bit vectors (packed wr_item_t).
interface ili934x_wr_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ITEM_W = 9
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][ITEM_W-1:0] req_item;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;
  logic                         fifo_valid;
  logic [ITEM_W-1:0]            fifo_item;
  logic                         fifo_ready;
  logic [ID_W-1:0]              grant_id;
  logic                         busy;
  logic                         abort;

  // master: requesters plus the FIFO's ready; slave: the arbiter itself
  modport master (
    output req_valid, req_item, req_last, fifo_ready,
    input  req_ready, fifo_valid, fifo_item, grant_id, busy, abort
  );

  modport slave (
    input  req_valid, req_item, req_last, fifo_ready,
    output req_ready, fifo_valid, fifo_item, grant_id, busy, abort
  );
endinterface

// File: rtl/ili934x_wr_arbiter.sv
// Burst-atomic round-robin arbiter in front of the ILI934x write-item FIFO.
// Optional lock watchdog: define ILI934X_ARB_WATCHDOG_EN.
module ili934x_wr_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ili934x_wr_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] w_owner_next;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_rr_ptr_next;

  logic [ID_W-1:0] w_scan_idx;
  logic [ID_W-1:0] w_rr_sel;
  logic            w_rr_hit;
  logic [ID_W-1:0] w_sel;
  logic            w_any;
  logic            w_xfer;

  function automatic logic [ID_W-1:0] f_wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

`ifdef ILI934X_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic [WD_W-1:0] w_wd_cnt_next;
  logic            r_abort;
  logic            w_abort_next;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Round-robin scan starting at rr_ptr; falls back to owner when nobody asks
  always_comb begin
    w_scan_idx = r_rr_ptr;
    w_rr_sel   = r_owner;
    w_rr_hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_rr_hit && bus.req_valid[w_scan_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_sel = w_scan_idx;
      end
      w_scan_idx = f_wrap_inc(w_scan_idx);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
`ifdef ILI934X_ARB_WATCHDOG_EN
      r_wd_cnt <= '0;
      r_abort  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_owner  <= w_owner_next;
      r_rr_ptr <= w_rr_ptr_next;
`ifdef ILI934X_ARB_WATCHDOG_EN
      r_wd_cnt <= w_wd_cnt_next;
      r_abort  <= w_abort_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_owner_next  = r_owner;
    w_rr_ptr_next = r_rr_ptr;
`ifdef ILI934X_ARB_WATCHDOG_EN
    w_abort_next  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          if (bus.req_last[w_sel]) begin
            w_rr_ptr_next = f_wrap_inc(w_sel);
          end else begin
            w_state_next = ST_LOCKED;
            w_owner_next = w_sel;
          end
        end
      end
      ST_LOCKED: begin
        if (w_xfer && bus.req_last[r_owner]) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = f_wrap_inc(r_owner);
        end
`ifdef ILI934X_ARB_WATCHDOG_EN
        else if (!w_xfer && r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = f_wrap_inc(r_owner);
          w_abort_next  = 1'b1;
        end
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
`ifdef ILI934X_ARB_WATCHDOG_EN
    // Counts only stalled cycles of a lock that survives this cycle
    w_wd_cnt_next = (r_state == ST_LOCKED && !w_xfer && w_state_next == ST_LOCKED)
                    ? r_wd_cnt + 1'b1 : '0;
`endif
  end

  // Outputs: zero-latency datapath from the selected requester
  always_comb begin
    w_any          = |bus.req_valid;
    w_sel          = (r_state == ST_LOCKED) ? r_owner : w_rr_sel;
    bus.fifo_valid = bus.req_valid[w_sel];
    bus.fifo_item  = bus.req_item[w_sel];
    bus.grant_id   = w_sel;
    bus.busy       = (r_state == ST_LOCKED);
    w_xfer         = bus.req_valid[w_sel] && bus.fifo_ready;
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign bus.req_ready[gi] = bus.fifo_ready && (w_sel == ID_W'(gi)) &&
                                 (r_state == ST_LOCKED || w_any);
    end
  endgenerate

`ifdef ILI934X_ARB_WATCHDOG_EN
  assign bus.abort = r_abort;
`else
  assign bus.abort = 1'b0;
`endif
endmodule
